// File: rtl/cmsdk_ahb_default_slave_ext.sv
// AHB default slave: zero-wait OKAY for IDLE/BUSY, WAIT_STATES waits then a two-cycle ERROR for
// NONSEQ/SEQ, saturating error counter; first-fault capture when DEFAULT_SLAVE_ERR_CAPTURE_EN is defined.
module cmsdk_ahb_default_slave_ext #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    input  logic                  ERR_CLR,
    output logic [CNT_WIDTH-1:0]  ERR_COUNT,
    output logic                  ERR_VALID,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic                  ERR_WRITE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam logic [1:0]           ST_HIT    = (WAIT_STATES > 0) ? ST_WAIT : ST_ERR1;
    localparam logic [3:0]           WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [1:0] state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       accept;
    logic       accept_taken;
    logic       unused_htrans;

    assign accept        = HSEL & HREADY & HTRANS[1];
    // Only IDLE and ERR2 complete a data phase, so only there can a new transfer be taken.
    assign accept_taken  = accept & ((state == ST_IDLE) | (state == ST_ERR2));
    assign unused_htrans = HTRANS[0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt    = ST_HIT;
                    wait_cnt_nxt = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = ST_ERR1;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            ST_ERR2: begin
                if (accept) begin
                    state_nxt    = ST_HIT;
                    wait_cnt_nxt = WAIT_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= 2'b00;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            HREADYOUT <= (state_nxt == ST_IDLE) | (state_nxt == ST_ERR2);
            HRESP     <= {1'b0, (state_nxt == ST_ERR1) | (state_nxt == ST_ERR2)};
        end
    end

    // Clear wins over increment, but a coincident fault still counts as the first one.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_COUNT <= '0;
        end else if (ERR_CLR) begin
            ERR_COUNT <= accept_taken ? CNT_WIDTH'(1) : '0;
        end else if (accept_taken && (ERR_COUNT != CNT_MAX)) begin
            ERR_COUNT <= ERR_COUNT + CNT_WIDTH'(1);
        end
    end

`ifdef DEFAULT_SLAVE_ERR_CAPTURE_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_VALID <= 1'b0;
            ERR_ADDR  <= '0;
            ERR_WRITE <= 1'b0;
        end else if (ERR_CLR) begin
            ERR_VALID <= accept_taken;
            ERR_ADDR  <= accept_taken ? HADDR : '0;
            ERR_WRITE <= accept_taken & HWRITE;
        end else if (accept_taken && !ERR_VALID) begin
            ERR_VALID <= 1'b1;
            ERR_ADDR  <= HADDR;
            ERR_WRITE <= HWRITE;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = ^{HADDR, HWRITE};
    assign ERR_VALID      = 1'b0;
    assign ERR_ADDR       = '0;
    assign ERR_WRITE      = 1'b0;
`endif

endmodule

// File: tb/tb_cmsdk_ahb_default_slave_ext.sv
// Bench for cmsdk_ahb_default_slave_ext: two instances (WAIT_STATES=0/CNT_WIDTH=8 and
// WAIT_STATES=3/CNT_WIDTH=2); directed table, hand sequences, then random traffic vs a model.
module tb_cmsdk_ahb_default_slave_ext;

`ifdef DEFAULT_SLAVE_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    localparam int WS[2]   = '{0, 3};
    localparam int CMAX[2] = '{255, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel[2];
    logic [1:0]  trans[2];
    logic        wr[2];
    logic        rdy[2];
    logic [31:0] addr[2];
    logic        clr[2];
    logic        rdyo[2];
    logic [1:0]  resp[2];
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;
    logic        vld[2];
    logic [31:0] eaddr[2];
    logic        ewr[2];

    int n_vec = 0;
    int n_bad = 0;

    // Model: cycles left in the current data phase (0 = idle), plus counter and capture state.
    int          m_rem[2];
    int          m_cnt[2];
    bit          m_v[2];
    logic [31:0] m_a[2];
    bit          m_w[2];

    cmsdk_ahb_default_slave_ext #(.ADDR_WIDTH(32), .WAIT_STATES(0), .CNT_WIDTH(8)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[0]), .HADDR(addr[0]), .HTRANS(trans[0]),
        .HWRITE(wr[0]), .HREADY(rdy[0]), .HREADYOUT(rdyo[0]), .HRESP(resp[0]), .ERR_CLR(clr[0]),
        .ERR_COUNT(cnt0), .ERR_VALID(vld[0]), .ERR_ADDR(eaddr[0]), .ERR_WRITE(ewr[0])
    );

    cmsdk_ahb_default_slave_ext #(.ADDR_WIDTH(32), .WAIT_STATES(3), .CNT_WIDTH(2)) dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel[1]), .HADDR(addr[1]), .HTRANS(trans[1]),
        .HWRITE(wr[1]), .HREADY(rdy[1]), .HREADYOUT(rdyo[1]), .HRESP(resp[1]), .ERR_CLR(clr[1]),
        .ERR_COUNT(cnt1), .ERR_VALID(vld[1]), .ERR_ADDR(eaddr[1]), .ERR_WRITE(ewr[1])
    );

    typedef struct {
        bit          sel;
        bit [1:0]    trans;
        bit          wr;
        bit          rdy;
        logic [31:0] addr;
        bit          clr;
        bit          e_rdyo;
        bit [1:0]    e_resp;
        int          e_cnt;
        bit          e_v;
        logic [31:0] e_a;
        bit          e_w;
    } vec_t;

    vec_t tbl[15];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(int d, bit s, bit [1:0] t, bit w, bit r, logic [31:0] a, bit c);
        sel[d] = s; trans[d] = t; wr[d] = w; rdy[d] = r; addr[d] = a; clr[d] = c;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rem[d] = 0; m_cnt[d] = 0; m_v[d] = 1'b0; m_a[d] = 32'h0; m_w[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit acc;
            acc = sel[d] & rdy[d] & trans[d][1] & (m_rem[d] <= 1);
            if (clr[d]) begin
                m_cnt[d] = acc ? 1 : 0;
                m_v[d]   = acc;
                m_a[d]   = acc ? addr[d] : 32'h0;
                m_w[d]   = acc & wr[d];
            end else if (acc) begin
                if (m_cnt[d] < CMAX[d]) m_cnt[d] = m_cnt[d] + 1;
                if (!m_v[d]) begin
                    m_v[d] = 1'b1; m_a[d] = addr[d]; m_w[d] = wr[d];
                end
            end
            if (acc)            m_rem[d] = WS[d] + 2;
            else if (m_rem[d] > 0) m_rem[d] = m_rem[d] - 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
    endtask

    task automatic check_model(int d, string tag);
        logic [31:0] c;
        c = (d == 0) ? 32'(cnt0) : 32'(cnt1);
        check({tag, ".hreadyout"}, 32'(rdyo[d]), 32'(m_rem[d] <= 1));
        check({tag, ".hresp"}, 32'(resp[d]), (m_rem[d] == 1 || m_rem[d] == 2) ? 32'd1 : 32'd0);
        check({tag, ".count"}, c, 32'(m_cnt[d]));
        check({tag, ".valid"}, 32'(vld[d]), CAP ? 32'(m_v[d]) : 32'd0);
        check({tag, ".addr"}, eaddr[d], CAP ? m_a[d] : 32'd0);
        check({tag, ".write"}, 32'(ewr[d]), CAP ? 32'(m_w[d]) : 32'd0);
    endtask

    // Full checked error sequence on the WAIT_STATES=3 instance; expected count given by caller.
    task automatic b_err_seq(string tag, logic [31:0] a, bit w, int exp_cnt);
        bit       e_rdy[5]  = '{0, 0, 0, 0, 1};
        bit [1:0] e_resp[5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        drv(1, 1, 2'b10, w, 1, a, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            drv(1, 1, 2'b00, 0, 0, 32'h0, 0);
            check($sformatf("%s.dp%0d.hreadyout", tag, i), 32'(rdyo[1]), 32'(e_rdy[i]));
            check($sformatf("%s.dp%0d.hresp", tag, i), 32'(resp[1]), 32'(e_resp[i]));
        end
        drv(1, 1, 2'b00, 0, 1, 32'h0, 0);
        step();
        check({tag, ".idle.hreadyout"}, 32'(rdyo[1]), 32'd1);
        check({tag, ".idle.hresp"}, 32'(resp[1]), 32'd0);
        check({tag, ".count"}, 32'(cnt1), 32'(exp_cnt));
    endtask

    // Unchecked fault on the WAIT_STATES=3 instance, ending back in IDLE.
    task automatic b_fault(logic [31:0] a, bit w, bit c);
        drv(1, 1, 2'b10, w, 1, a, c);
        step();
        drv(1, 1, 2'b00, 0, 0, 32'h0, 0);
        repeat (4) step();
        drv(1, 1, 2'b00, 0, 1, 32'h0, 0);
        step();
    endtask

    initial begin
        tbl[0]  = '{1, 2'b00, 0, 1, 32'h0,         0, 1, 2'b00, 0, 0, 32'h0,         0};
        tbl[1]  = '{1, 2'b10, 1, 1, 32'h4000_0010, 0, 0, 2'b01, 1, 1, 32'h4000_0010, 1};
        tbl[2]  = '{1, 2'b00, 0, 0, 32'h0,         0, 1, 2'b01, 1, 1, 32'h4000_0010, 1};
        tbl[3]  = '{1, 2'b00, 0, 1, 32'h0,         1, 1, 2'b00, 0, 0, 32'h0,         0};
        tbl[4]  = '{1, 2'b10, 0, 1, 32'h10,        0, 0, 2'b01, 1, 1, 32'h10,        0};
        tbl[5]  = '{1, 2'b00, 0, 0, 32'h0,         0, 1, 2'b01, 1, 1, 32'h10,        0};
        tbl[6]  = '{1, 2'b10, 1, 1, 32'h20,        0, 0, 2'b01, 2, 1, 32'h10,        0};
        tbl[7]  = '{1, 2'b00, 0, 0, 32'h0,         0, 1, 2'b01, 2, 1, 32'h10,        0};
        tbl[8]  = '{1, 2'b00, 0, 1, 32'h0,         0, 1, 2'b00, 2, 1, 32'h10,        0};
        tbl[9]  = '{1, 2'b01, 0, 1, 32'h50,        0, 1, 2'b00, 2, 1, 32'h10,        0};
        tbl[10] = '{0, 2'b10, 1, 1, 32'h60,        0, 1, 2'b00, 2, 1, 32'h10,        0};
        tbl[11] = '{1, 2'b10, 1, 0, 32'h70,        0, 1, 2'b00, 2, 1, 32'h10,        0};
        tbl[12] = '{1, 2'b11, 0, 1, 32'h30,        1, 0, 2'b01, 1, 1, 32'h30,        0};
        tbl[13] = '{1, 2'b00, 0, 0, 32'h0,         0, 1, 2'b01, 1, 1, 32'h30,        0};
        tbl[14] = '{1, 2'b00, 0, 1, 32'h0,         1, 1, 2'b00, 0, 0, 32'h0,         0};

        rst_n = 1'b0;
        model_reset();
        for (int d = 0; d < 2; d++) drv(d, 0, 2'b00, 0, 1, 32'h0, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        check_model(0, "reset0");
        check_model(1, "reset1");

        // Directed table on the zero-wait instance.
        for (int i = 0; i < 15; i++) begin
            drv(0, tbl[i].sel, tbl[i].trans, tbl[i].wr, tbl[i].rdy, tbl[i].addr, tbl[i].clr);
            step();
            check($sformatf("tbl%0d.hreadyout", i), 32'(rdyo[0]), 32'(tbl[i].e_rdyo));
            check($sformatf("tbl%0d.hresp", i), 32'(resp[0]), 32'(tbl[i].e_resp));
            check($sformatf("tbl%0d.count", i), 32'(cnt0), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d.valid", i), 32'(vld[0]), CAP ? 32'(tbl[i].e_v) : 32'd0);
            check($sformatf("tbl%0d.addr", i), eaddr[0], CAP ? tbl[i].e_a : 32'd0);
            check($sformatf("tbl%0d.write", i), 32'(ewr[0]), CAP ? 32'(tbl[i].e_w) : 32'd0);
        end
        drv(0, 0, 2'b00, 0, 1, 32'h0, 0);

        // Three-wait-state read, then saturation of the 2-bit counter.
        b_err_seq("ws3", 32'h100, 0, 1);
        check("ws3.valid", 32'(vld[1]), CAP ? 32'd1 : 32'd0);
        check("ws3.addr", eaddr[1], CAP ? 32'h100 : 32'd0);
        for (int n = 2; n <= 5; n++) begin
            b_fault(32'h100 + 32'(n * 16), 1, 0);
            check($sformatf("sat%0d.count", n), 32'(cnt1), (n < 3) ? 32'(n) : 32'd3);
        end
        check("sat.addr_kept", eaddr[1], CAP ? 32'h100 : 32'd0);
        drv(1, 1, 2'b10, 1, 1, 32'h200, 1);
        step();
        check("clr_acc.count", 32'(cnt1), 32'd1);
        check("clr_acc.valid", 32'(vld[1]), CAP ? 32'd1 : 32'd0);
        check("clr_acc.addr", eaddr[1], CAP ? 32'h200 : 32'd0);
        check("clr_acc.write", 32'(ewr[1]), CAP ? 32'd1 : 32'd0);
        drv(1, 1, 2'b00, 0, 0, 32'h0, 0);
        repeat (4) step();
        drv(1, 1, 2'b00, 0, 1, 32'h0, 0);
        step();

        // Reset asserted while in WAIT takes effect without a clock edge.
        drv(1, 1, 2'b10, 0, 1, 32'h300, 0);
        step();
        drv(1, 1, 2'b00, 0, 0, 32'h0, 0);
        step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_wait.hreadyout", 32'(rdyo[1]), 32'd1);
        check("rst_wait.hresp", 32'(resp[1]), 32'd0);
        check("rst_wait.count", 32'(cnt1), 32'd0);
        check("rst_wait.valid", 32'(vld[1]), 32'd0);
        check("rst_wait.addr", eaddr[1], 32'd0);
        check("rst_wait.write", 32'(ewr[1]), 32'd0);
        drv(1, 1, 2'b00, 0, 1, 32'h0, 0);
        step();
        #2 rst_n = 1'b1;
        b_err_seq("post_rst", 32'h400, 1, 1);
        check("post_rst.addr", eaddr[1], CAP ? 32'h400 : 32'd0);

        // Random traffic on both instances against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                bit r;
                if (m_rem[d] >= 2)      r = 1'b0;
                else if (m_rem[d] == 1) r = 1'b1;
                else                    r = ($urandom_range(0, 7) != 0);
                drv(d, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    r, $urandom, ($urandom_range(0, 31) == 0));
            end
            step();
            check_model(0, "rnd0");
            check_model(1, "rnd1");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
